// File: rtl/verificador_de_senha.sv
// Keypad password lock: timed unlock, wrong-attempt alarm and two-step password change.
// Defining BLOQUEIO_EN adds a lockout after MAX_TENTATIVAS consecutive failures.
module verificador_de_senha #(
    parameter logic [79:0] SENHA_PADRAO   = 80'hFFFF_FFFF_FFFF_FFFF_1234,
    parameter int          T_ABERTO       = 500,
    parameter int          T_ERRO         = 100,
    parameter int          T_BLOQUEIO     = 1000,
    parameter int          MAX_TENTATIVAS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    input  logic        modo_config,
    output logic        teclado_enable,
    output logic        destrancar,
    output logic        alarme,
    output logic        bloqueado
);

    if (T_ABERTO < 1 || T_ABERTO > 65536 || T_ERRO < 1 || T_ERRO > 65536 ||
        T_BLOQUEIO < 1 || T_BLOQUEIO > 65536 || MAX_TENTATIVAS < 1) begin : g_param_invalido
        $error("verificador_de_senha: timer values must be 1..65536 and MAX_TENTATIVAS >= 1");
    end

    typedef enum logic [2:0] {
        INICIO,
        AGUARDA,
        VERIFICA,
        ABERTO,
        ERRO,
        CFG_NOVA,
        CFG_CONFIRMA
`ifdef BLOQUEIO_EN
        , BLOQUEADO
`endif
    } estado_t;

    localparam logic [15:0] CARGA_ABERTO = 16'(T_ABERTO - 1);
    localparam logic [15:0] CARGA_ERRO   = 16'(T_ERRO - 1);

    function automatic logic eh_cancel(input logic [79:0] d);
        return (d == {20{4'hB}}) || (d == {20{4'hE}});
    endfunction

    // A password needs at least four real digits in the most recent positions.
    function automatic logic eh_curta(input logic [79:0] d);
        return (d[3:0] == 4'hF) || (d[7:4] == 4'hF) ||
               (d[11:8] == 4'hF) || (d[15:12] == 4'hF);
    endfunction

    estado_t     estado_q, estado_d;
    logic [15:0] timer_q, timer_d;
    logic [79:0] senha_q;
    logic [79:0] candidato_q;
    logic [79:0] entrada_q;
    logic        valid_ok;
    logic        captura_entrada;
    logic        captura_cand;
    logic        grava_senha;
    logic        falha_cfg;

`ifdef BLOQUEIO_EN
    localparam int          FALHAS_W   = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [15:0] CARGA_BLOQ = 16'(T_BLOQUEIO - 1);
    localparam logic [FALHAS_W-1:0] FALHAS_MAX = FALHAS_W'(MAX_TENTATIVAS);

    logic [FALHAS_W-1:0] falhas_q;
    logic                inc_falha;
    logic                zera_falha;
`endif

    // Keypad strobes only count while the registered enable is high.
    assign valid_ok = digitos_valid && teclado_enable;

    always_comb begin
        estado_d        = estado_q;
        captura_entrada = 1'b0;
        captura_cand    = 1'b0;
        grava_senha     = 1'b0;
        falha_cfg       = 1'b0;
`ifdef BLOQUEIO_EN
        inc_falha       = 1'b0;
        zera_falha      = 1'b0;
`endif
        case (estado_q)
            INICIO: estado_d = AGUARDA;
            AGUARDA: begin
                if (valid_ok && !eh_cancel(digitos_value)) begin
                    captura_entrada = 1'b1;
                    estado_d        = VERIFICA;
                end
            end
            VERIFICA: begin
                if (entrada_q == senha_q) begin
                    estado_d = ABERTO;
`ifdef BLOQUEIO_EN
                    zera_falha = 1'b1;
`endif
                end else begin
                    estado_d = ERRO;
`ifdef BLOQUEIO_EN
                    inc_falha = 1'b1;
`endif
                end
            end
            ABERTO: begin
                if (timer_q == 16'd0) estado_d = modo_config ? CFG_NOVA : AGUARDA;
            end
            ERRO: begin
                if (timer_q == 16'd0) begin
`ifdef BLOQUEIO_EN
                    estado_d = (falhas_q == FALHAS_MAX) ? BLOQUEADO : AGUARDA;
`else
                    estado_d = AGUARDA;
`endif
                end
            end
`ifdef BLOQUEIO_EN
            BLOQUEADO: begin
                if (timer_q == 16'd0) begin
                    zera_falha = 1'b1;
                    estado_d   = AGUARDA;
                end
            end
`endif
            CFG_NOVA: begin
                if (valid_ok) begin
                    if (eh_cancel(digitos_value) || eh_curta(digitos_value)) begin
                        estado_d = AGUARDA;
                    end else begin
                        captura_cand = 1'b1;
                        estado_d     = CFG_CONFIRMA;
                    end
                end
            end
            CFG_CONFIRMA: begin
                if (valid_ok) begin
                    estado_d = AGUARDA;
                    if (digitos_value == candidato_q) grava_senha = 1'b1;
                    else                              falha_cfg   = 1'b1;
                end
            end
            default: estado_d = INICIO;
        endcase

        // Timers reload when a timed state is entered and free-run down to zero otherwise.
        timer_d = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
        if (estado_d != estado_q) begin
            case (estado_d)
                ABERTO:    timer_d = CARGA_ABERTO;
                ERRO:      timer_d = CARGA_ERRO;
`ifdef BLOQUEIO_EN
                BLOQUEADO: timer_d = CARGA_BLOQ;
`endif
                default:   timer_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q       <= INICIO;
            timer_q        <= 16'd0;
            senha_q        <= SENHA_PADRAO;
            candidato_q    <= '1;
            teclado_enable <= 1'b0;
            destrancar     <= 1'b0;
            alarme         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            timer_q        <= timer_d;
            if (captura_cand) candidato_q <= digitos_value;
            if (grava_senha)  senha_q     <= candidato_q;
            // Outputs are decoded from the next state so they line up with estado_q.
            teclado_enable <= (estado_d == AGUARDA) || (estado_d == CFG_NOVA) ||
                              (estado_d == CFG_CONFIRMA);
            destrancar     <= (estado_d == ABERTO);
            alarme         <= (estado_d == ERRO) || falha_cfg;
        end
    end

    always_ff @(posedge clk) begin
        if (captura_entrada) entrada_q <= digitos_value;
    end

`ifdef BLOQUEIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            falhas_q  <= '0;
            bloqueado <= 1'b0;
        end else begin
            if (zera_falha)                              falhas_q <= '0;
            else if (inc_falha && falhas_q != FALHAS_MAX) falhas_q <= falhas_q + 1'b1;
            bloqueado <= (estado_d == BLOQUEADO);
        end
    end
`else
    assign bloqueado = 1'b0;
`endif

endmodule

// File: tb/tb_verificador_de_senha.sv
// Scoreboard bench for verificador_de_senha: each keypad entry queues the expected
// response (cycles of destrancar/alarme/bloqueado and idle check cycles) and the monitor compares it.
module tb_verificador_de_senha;

    localparam logic [79:0] S1234  = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [79:0] S9999  = 80'hFFFF_FFFF_FFFF_FFFF_9999;
    localparam logic [79:0] S5678  = 80'hFFFF_FFFF_FFFF_FFFF_5678;
    localparam logic [79:0] S5679  = 80'hFFFF_FFFF_FFFF_FFFF_5679;
    localparam logic [79:0] SCURTA = 80'hFFFF_FFFF_FFFF_FFFF_F123;
    localparam logic [79:0] SB     = {20{4'hB}};
    localparam logic [79:0] SE     = {20{4'hE}};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] digitos_value = '0;
    logic        digitos_valid = 1'b0;
    logic        modo_config = 1'b0;
    logic        teclado_enable;
    logic        destrancar;
    logic        alarme;
    logic        bloqueado;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int destr;
        int alarme;
        int bloq;
        int verif;
    } exp_t;

    exp_t sb[$];

    verificador_de_senha dut (
        .clk            (clk),
        .rst            (rst),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .modo_config    (modo_config),
        .teclado_enable (teclado_enable),
        .destrancar     (destrancar),
        .alarme         (alarme),
        .bloqueado      (bloqueado)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Watches the DUT until the keypad is enabled again, optionally pulsing a strobe mid-way.
    task automatic mede(input string tag, input int pulso_em, input logic [79:0] pulso_val);
        int   nd, na, nb, nv, ciclo;
        bit   fim;
        exp_t e;
        nd = 0; na = 0; nb = 0; nv = 0; ciclo = 0; fim = 1'b0;
        while (!fim && ciclo < 3000) begin
            if (destrancar) nd++;
            if (alarme)     na++;
            if (bloqueado)  nb++;
            if (!teclado_enable && !destrancar && !alarme && !bloqueado) nv++;
            if (teclado_enable) fim = 1'b1;
            else begin
                if (ciclo == pulso_em) begin
                    digitos_value = pulso_val;
                    digitos_valid = 1'b1;
                end
                @(posedge clk); #1;
                digitos_valid = 1'b0;
                ciclo++;
            end
        end
        check({tag, ":fim"}, 32'(fim), 32'd1);
        e = sb.pop_front();
        check({tag, ":destrancar"}, nd, e.destr);
        check({tag, ":alarme"},     na, e.alarme);
        check({tag, ":bloqueado"},  nb, e.bloq);
        check({tag, ":verifica"},   nv, e.verif);
    endtask

    task automatic tentativa(input string tag, input logic [79:0] valor,
                             input int e_destr, input int e_alarme, input int e_bloq,
                             input int e_verif, input int pulso_em, input logic [79:0] pulso_val);
        exp_t e;
        e.destr = e_destr; e.alarme = e_alarme; e.bloq = e_bloq; e.verif = e_verif;
        sb.push_back(e);
        check({tag, ":pronto"}, 32'(teclado_enable), 32'd1);
        digitos_value = valor;
        digitos_valid = 1'b1;
        @(posedge clk); #1;
        digitos_valid = 1'b0;
        mede(tag, pulso_em, pulso_val);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_teclado",    32'(teclado_enable), 32'd0);
        check("rst_destrancar", 32'(destrancar),     32'd0);
        check("rst_alarme",     32'(alarme),         32'd0);
        check("rst_bloqueado",  32'(bloqueado),      32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("inicio_aguarda", 32'(teclado_enable), 32'd1);

        tentativa("abre_1234", S1234, 500, 0, 0, 1, -1, '0);
        tentativa("erro_9999", S9999, 0, 100, 0, 1, 10, S1234);
        tentativa("cancel_b",  SB, 0, 0, 0, 0, -1, '0);
        tentativa("cancel_e",  SE, 0, 0, 0, 0, -1, '0);
`ifdef BLOQUEIO_EN
        tentativa("erro_2",    S9999, 0, 100, 0, 1, -1, '0);
        tentativa("bloqueio",  S9999, 0, 100, 1000, 1, 151, S1234);
        tentativa("pos_bloq",  S9999, 0, 100, 0, 1, -1, '0);
`else
        for (int i = 0; i < 5; i++) begin
            tentativa($sformatf("erro_seq%0d", i), S9999, 0, 100, 0, 1, -1, '0);
        end
`endif
        tentativa("abre_pos_erros", S1234, 500, 0, 0, 1, -1, '0);

        modo_config = 1'b1;
        tentativa("cfg_abre_curta", S1234, 500, 0, 0, 1, -1, '0);
        modo_config = 1'b0;
        tentativa("cfg_curta",      SCURTA, 0, 0, 0, 0, -1, '0);

        modo_config = 1'b1;
        tentativa("cfg_abre_falha", S1234, 500, 0, 0, 1, -1, '0);
        modo_config = 1'b0;
        tentativa("cfg_nova_5678",  S5678, 0, 0, 0, 0, -1, '0);
        tentativa("cfg_conf_5679",  S5679, 0, 1, 0, 0, -1, '0);
        tentativa("abre_1234_mant", S1234, 500, 0, 0, 1, -1, '0);

        modo_config = 1'b1;
        tentativa("cfg_abre_ok",    S1234, 500, 0, 0, 1, -1, '0);
        modo_config = 1'b0;
        tentativa("cfg_nova_ok",    S5678, 0, 0, 0, 0, -1, '0);
        tentativa("cfg_conf_ok",    S5678, 0, 0, 0, 0, -1, '0);
        tentativa("1234_rejeitada", S1234, 0, 100, 0, 1, -1, '0);
        tentativa("abre_5678",      S5678, 500, 0, 0, 1, -1, '0);

        check("rst_meio_pronto", 32'(teclado_enable), 32'd1);
        digitos_value = S5678;
        digitos_valid = 1'b1;
        @(posedge clk); #1;
        digitos_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_meio_aberto", 32'(destrancar), 32'd1);
        rst = 1'b0;
        #2;
        check("rst_meio_destr_async", 32'(destrancar),     32'd0);
        check("rst_meio_teclado",     32'(teclado_enable), 32'd0);
        check("rst_meio_alarme",      32'(alarme),         32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_meio_inicio", 32'(teclado_enable), 32'd1);
        tentativa("pos_rst_1234", S1234, 500, 0, 0, 1, -1, '0);
        tentativa("pos_rst_5678", S5678, 0, 100, 0, 1, -1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/verificador_de_senha.md
VERIFICADOR_DE_SENHA -- requirements
Module: verificador_de_senha

Interface
REQ-001 The block SHALL have parameter SENHA_PADRAO, default 80'hFFFF_FFFF_FFFF_FFFF_1234: the stored password after reset, as 20 nibbles with digit[0] most recent and 0xF marking an empty digit.
REQ-002 The block SHALL have parameter T_ABERTO, default 500: the number of cycles destrancar is held high.
REQ-003 The block SHALL have parameter T_ERRO, default 100: the number of cycles alarme is held high after a wrong attempt.
REQ-004 The block SHALL have parameter T_BLOQUEIO, default 1000: the number of cycles the lockout lasts.
REQ-005 The block SHALL have parameter MAX_TENTATIVAS, default 3: the number of consecutive failures that triggers lockout.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port digitos_value, input, 80 bits: the keypad digit array (20×4 bits).
REQ-009 The block SHALL have port digitos_valid, input, 1 bit: a one-cycle pulse, with digitos_value qualified in that cycle.
REQ-010 The block SHALL have port modo_config, input, 1 bit: a request to change the password, sampled while unlocked.
REQ-011 The block SHALL have port teclado_enable, output, 1 bit: enables the keypad decoder.
REQ-012 The block SHALL have port destrancar, output, 1 bit: the lock actuator.
REQ-013 The block SHALL have port alarme, output, 1 bit: the wrong-password indicator.
REQ-014 The block SHALL have port bloqueado, output, 1 bit: the lockout indicator.

Function
REQ-015 The FSM SHALL have states INICIO, AGUARDA, VERIFICA, ABERTO, ERRO, BLOQUEADO, CFG_NOVA and CFG_CONFIRMA; all outputs SHALL be registered.
REQ-016 Each of these conditions SHALL be classified on the digitos_valid cycle:
- "cancel": all nibbles 0xB, or all nibbles 0xE.
- "curta": any of digits[3:0] is 0xF.
- "normal": otherwise.
REQ-017 In INICIO, the FSM SHALL go to AGUARDA on the next cycle.
REQ-018 In AGUARDA, teclado_enable SHALL be 1.
- On a normal or curta valid: capture the 80 bits and go to VERIFICA.
- On a cancel valid: stay in AGUARDA, with no attempt counted.
REQ-019 In VERIFICA, teclado_enable SHALL be 0, for exactly 1 cycle.
- Full 80-bit match with the stored password: go to ABERTO and clear the failure counter.
- Otherwise: go to ERRO and increment the failure counter, saturating at MAX_TENTATIVAS.
REQ-020 In ABERTO, destrancar SHALL be 1 for exactly T_ABERTO cycles. At expiry, if modo_config=1, the FSM SHALL go to CFG_NOVA; otherwise it SHALL go to AGUARDA.
REQ-021 In ERRO, alarme SHALL be 1 for exactly T_ERRO cycles. At expiry, the FSM SHALL go to AGUARDA, except as in REQ-031.
REQ-022 In CFG_NOVA, teclado_enable SHALL be 1.
- Normal valid: capture the candidate and go to CFG_CONFIRMA.
- Cancel or curta valid: go to AGUARDA with the stored password unchanged.
REQ-023 In CFG_CONFIRMA, teclado_enable SHALL be 1.
- Valid equal to the candidate: the stored password SHALL take the candidate value, and the FSM SHALL go to AGUARDA.
- Any other valid: the stored password is unchanged, alarme pulses for 1 cycle, and the FSM goes to AGUARDA.
REQ-024 The block SHALL ignore digitos_valid in any state whose teclado_enable is 0, and SHALL ignore it in the same cycle that teclado_enable deasserts.
REQ-025 Timers SHALL be 16-bit down-counters, loaded on state entry. Every T_* value SHALL be ≥1.
REQ-026 modo_config SHALL be ignored outside ABERTO.

Reset
REQ-027 While rst=0, the state SHALL be INICIO.
REQ-028 While rst=0, the outputs SHALL be: teclado_enable=0, destrancar=0, alarme=0, bloqueado=0.
REQ-029 While rst=0, the failure counter and timers SHALL be 0, and the stored password SHALL be SENHA_PADRAO.
REQ-030 Reset mid-operation, including during CFG_*, SHALL abort immediately and SHALL discard any candidate password.

Configuration
REQ-031 With macro BLOQUEIO_EN defined:
- At ERRO expiry with the counter equal to MAX_TENTATIVAS, the FSM SHALL go to BLOQUEADO.
- In BLOQUEADO: bloqueado=1 and teclado_enable=0 for T_BLOQUEIO cycles; then the counter clears and the FSM goes to AGUARDA.
REQ-032 Without BLOQUEIO_EN:
- The failure counter and the BLOQUEADO state SHALL be absent.
- bloqueado SHALL be tied to 0.
- ERRO SHALL always return to AGUARDA.

Verification
REQ-033 Reset, then a valid with ...F1234 → 1 cycle of VERIFICA with teclado_enable=0, then destrancar=1 for exactly 500 cycles, then teclado_enable=1.
REQ-034 A valid with ...F9999 → alarme=1 for 100 cycles, destrancar stays 0, and the counter is 1.
REQ-035 With BLOQUEIO_EN, 3 wrong valids → bloqueado=1 for 1000 cycles, and a valid pulsed during that time is ignored. Then the counter is 0 and the password 1234 unlocks.
REQ-036 Without BLOQUEIO_EN, 5 wrong valids → bloqueado is never 1, and each valid produces 100 cycles of alarme.
REQ-037 Password change: unlock with modo_config=1, enter 5678, then confirm 5678 → 1234 now fails and 5678 unlocks. Confirming with 5679 instead → 1234 still unlocks.
REQ-038 An all-0xB valid, an all-0xE valid, and rst=0 asserted mid-ABERTO → no count and no alarme for the cancels; after the reset, destrancar falls asynchronously and the password is SENHA_PADRAO.
